// File: rtl/lstm_ctrl_pkg.sv
// Shared definitions for the LSTM sequence controller: width defaults and
// the controller FSM state encoding.
package lstm_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/lstm_out_slot.sv
// One-entry valid/ready holding register for the captured cell output.
// A load always wins, so an accept and a load in the same cycle replace
// the old entry with no bubble.
module lstm_out_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_last,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             last
);

  // Capture on load, drop valid on accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
      last  <= d_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequence controller for a single LSTM cell: issues one timestep per
// fire, selects zero initial state on the first step, captures h(t) into
// a one-entry output slot and signals completion.
module lstm_seq_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_x_valid,
  output logic             o_x_ready,
  output logic             o_cell_sel,
  output logic             o_cell_ce,
  input  logic [WIDTH-1:0] i_cell_h,
  output logic [WIDTH-1:0] o_y,
  output logic             o_y_valid,
  output logic             o_y_last,
  input  logic             i_y_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_step
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  ctrl_state_e      state, state_nx;
  logic [LEN_W-1:0] len_q;
  logic             fire;
  logic             last_step;
  logic             accept;

  // Step fires only in RUN with x present and a free output slot; reset
  // suppresses it so the cell state is never written while rst is high.
  assign fire      = o_x_ready && i_x_valid && !rst;
  // len_q is non-zero whenever RUN is entered, so len_q-1 cannot underflow.
  assign last_step = (o_step == (len_q - ONE));
  assign accept    = o_y_valid && i_y_ready;

  assign o_cell_ce  = fire;
  assign o_cell_sel = (o_step != '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx  = state;
    o_x_ready = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nx = (i_len != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        o_x_ready = !o_y_valid || i_y_ready;
        if (fire && last_step) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept) state_nx = ST_DONE;
      end
      ST_DONE: begin
        o_done   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Length latch and step counter; the length is only sampled on an
  // accepted start so later i_len changes cannot disturb a running sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      o_step <= '0;
    end else if (state == ST_IDLE && i_start) begin
      len_q  <= i_len;
      o_step <= '0;
    end else if (fire) begin
      o_step <= o_step + ONE;
    end
  end

  lstm_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (fire),
    .d      (i_cell_h),
    .d_last (last_step),
    .ready  (i_y_ready),
    .q      (o_y),
    .valid  (o_y_valid),
    .last   (o_y_last)
  );

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl: directed scenarios followed by
// randomized traffic, checked cycle by cycle against a behavioural model
// plus an in-order result scoreboard and per-run step counts.
module tb_lstm_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_x_valid;
  logic             o_x_ready;
  logic             o_cell_sel;
  logic             o_cell_ce;
  logic [WIDTH-1:0] i_cell_h;
  logic [WIDTH-1:0] o_y;
  logic             o_y_valid;
  logic             o_y_last;
  logic             i_y_ready;
  logic             o_busy;
  logic             o_done;
  logic [LEN_W-1:0] o_step;

  always #5 clk = ~clk;

  lstm_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_x_valid  (i_x_valid),
    .o_x_ready  (o_x_ready),
    .o_cell_sel (o_cell_sel),
    .o_cell_ce  (o_cell_ce),
    .i_cell_h   (i_cell_h),
    .o_y        (o_y),
    .o_y_valid  (o_y_valid),
    .o_y_last   (o_y_last),
    .i_y_ready  (i_y_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_step     (o_step)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 issuing, 2 draining, 3 done.
  int          m_phase = 0;
  int          m_len   = 0;
  int          m_step  = 0;
  bit          m_yv    = 0;
  bit          m_last  = 0;
  logic [31:0] m_y     = '0;
  // Scoreboard of results in issue order: {last, h}.
  logic [32:0] sb_q[$];
  int          run_len   = 0;
  int          run_fires = 0;
  int          done_seen = 0;

  // One clock cycle: drive inputs, check every output, advance the model.
  task automatic cyc(input bit st, input int ln, input bit xv, input bit yr, input bit r);
    bit          exp_rdy, exp_ce;
    logic [32:0] ent;
    logic [31:0] h;
    @(negedge clk);
    h         = $urandom;
    rst       = r;
    i_start   = st;
    i_len     = LEN_W'(ln);
    i_x_valid = xv;
    i_y_ready = yr;
    i_cell_h  = h;
    #1;
    exp_rdy = (m_phase == 1) && (!m_yv || yr);
    exp_ce  = exp_rdy && xv && !r;
    chk("x_ready", o_x_ready, exp_rdy);
    chk("cell_ce", o_cell_ce, exp_ce);
    chk("busy",    o_busy,    m_phase != 0);
    chk("done",    o_done,    m_phase == 3);
    chk("step",    o_step,    m_step);
    chk("y_valid", o_y_valid, m_yv);
    if (m_yv) begin
      chk("y",      o_y,      m_y);
      chk("y_last", o_y_last, m_last);
    end
    if (m_phase == 1) chk("cell_sel", o_cell_sel, m_step != 0);
    // Scoreboard: every consumed result comes out in issue order.
    if (!r && o_y_valid && yr) begin
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        ent = sb_q.pop_front();
        chk("sb_y",    o_y,      ent[31:0]);
        chk("sb_last", o_y_last, ent[32]);
      end
    end
    if (o_cell_ce) run_fires++;
    if (o_done && !r) begin
      done_seen++;
      chk("run_fires", run_fires, run_len);
    end
    // Model update for the coming edge.
    if (r) begin
      m_phase = 0; m_step = 0; m_yv = 0; m_last = 0; m_y = '0;
      sb_q.delete();
      run_fires = 0;
    end else begin
      bit acc, lastf;
      acc   = m_yv && yr;
      lastf = exp_ce && (m_step + 1 == m_len);
      case (m_phase)
        0: if (st) begin
             m_len = ln; m_step = 0; run_len = ln; run_fires = 0;
             m_phase = (ln != 0) ? 1 : 3;
           end
        1: if (lastf) m_phase = 2;
        2: if (acc) m_phase = 3;
        default: m_phase = 0;
      endcase
      if (exp_ce) begin
        m_y = h; m_yv = 1; m_last = lastf; m_step++;
        sb_q.push_back({lastf, h});
      end else if (acc) m_yv = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0);
  endtask

  initial begin
    int d0;
    rst = 1; i_start = 0; i_len = '0; i_x_valid = 0; i_y_ready = 0; i_cell_h = '0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    idle(2);

    // Back-to-back stream, len 3.
    d0 = done_seen;
    cyc(1, 3, 1, 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1, 0);
    chk("b2b_done", done_seen - d0, 1);

    // Output stall, len 2.
    cyc(1, 2, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0);

    // Zero length.
    d0 = done_seen;
    cyc(1, 0, 1, 1, 0);
    idle(3);
    chk("zero_done", done_seen - d0, 1);

    // Input gaps, len 4.
    cyc(1, 4, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, i[0] == 0, 1, 0);

    // Mid-sequence reset after 2 of 5 steps, then len 1.
    d0 = done_seen;
    cyc(1, 5, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 1);
    idle(3);
    chk("abort_no_done", done_seen - d0, 0);
    cyc(1, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0);

    // Start while busy with a different length.
    cyc(1, 3, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(1, 7, 1, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0);

    // Maximum length: no counter wrap.
    d0 = done_seen;
    cyc(1, 255, 1, 1, 0);
    for (int i = 0; i < 260; i++) cyc(0, 0, 1, 1, 0);
    chk("max_done", done_seen - d0, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6),
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 199) == 0);
    idle(20);
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lstm_seq_ctrl.md
LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: fixed-point data width, matching the cell datapath.
REQ-002 Parameter LEN_W, default 8: width of the sequence-length and step counters.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_start  in  1  begin a sequence; sampled only in IDLE.
REQ-006 i_len  in  LEN_W  number of timesteps; sampled with i_start.
REQ-007 i_x_valid  in  1  upstream has the current timestep x on the cell input bus.
REQ-008 o_x_ready  out  1  controller consumes x this cycle.
REQ-009 o_cell_sel  out  1  cell recurrence select: 0 means h(t-1)=0 and c(t-1)=0; 1 means use the stored state.
REQ-010 o_cell_ce  out  1  enable for the cell state registers.
REQ-011 i_cell_h  in  WIDTH  cell h output (combinational from the current x and the stored state).
REQ-012 o_y  out  WIDTH  captured h(t).
REQ-013 o_y_valid  out  1  o_y holds an unconsumed result.
REQ-014 o_y_last  out  1  o_y is the final timestep of the sequence.
REQ-015 i_y_ready  in  1  downstream accepts o_y.
REQ-016 o_busy  out  1  high in any state other than IDLE.
REQ-017 o_done  out  1  one-cycle pulse when a sequence completes.
REQ-018 o_step  out  LEN_W  index of the next timestep to issue (0-based).

Function
REQ-019 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE with i_start=1 and i_len!=0: latch i_len, clear o_step, go to RUN.
REQ-021 IDLE with i_start=1 and i_len=0: go to DONE with no timestep issued.
REQ-022 In RUN, o_x_ready SHALL equal (o_y_valid==0 || i_y_ready==1), so each timestep needs a free output slot.
REQ-023 A step fires when RUN && i_x_valid && o_x_ready; o_cell_ce SHALL be 1 only in a step-fire cycle and 0 in every other cycle, including all non-RUN states.
REQ-024 o_cell_sel SHALL be 0 when o_step==0 and 1 otherwise, so the first timestep of every sequence starts from zero state.
REQ-025 On a step fire, the following SHALL be registered on the same edge:
  - o_y <= i_cell_h
  - o_y_valid <= 1
  - o_y_last <= (o_step==len-1)
  - o_step <= o_step+1
REQ-026 Result latency SHALL be 1 cycle from step fire to o_y_valid.
REQ-027 o_y, o_y_valid and o_y_last SHALL hold unchanged while o_y_valid && !i_y_ready.
REQ-028 If the output is accepted with no new fire in the same cycle, o_y_valid SHALL fall to 0.
REQ-029 If the output is accepted and a step fires in the same cycle, the new result SHALL replace the old one with no bubble.
REQ-030 When the last step fires, the FSM SHALL go RUN->DRAIN.
REQ-031 In DRAIN, o_x_ready=0; when the last result is accepted, go to DONE.
REQ-032 DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-033 i_start SHALL be ignored outside IDLE.
REQ-034 i_len changes after the start cycle SHALL have no effect on the running sequence.
REQ-035 i_len equal to the maximum count (2^LEN_W-1) SHALL run exactly that many steps, with no counter wrap.

Reset
REQ-036 rst=1 SHALL force, on the next edge:
  - FSM to IDLE
  - o_step=0, o_y=0, o_y_valid=0, o_y_last=0, o_done=0
REQ-037 rst mid-sequence SHALL abandon the sequence with no o_done pulse; o_cell_ce=0 while rst is high.

Structure
REQ-038 The FSM state encodings and the width defaults SHALL live in a shared package lstm_ctrl_pkg.
REQ-039 The output register slot SHALL be a single sub-module lstm_out_slot, a one-entry valid/ready holding register; all other logic stays in lstm_seq_ctrl.

Verification
REQ-040 Back-to-back stream: i_len=3, i_x_valid and i_y_ready tied high. Required: three consecutive o_cell_ce pulses with o_cell_sel = 0,1,1; o_y_last on the 3rd result only; o_done 1 cycle after the 3rd o_y_valid.
REQ-041 Output stall: i_len=2, i_y_ready low for 4 cycles after the first result. Required: o_x_ready=0, o_cell_ce=0 and o_y stable for those 4 cycles; the 2nd step fires in the cycle i_y_ready rises.
REQ-042 Zero length: i_start with i_len=0. Required: o_done 1 cycle after start; o_cell_ce never asserted; o_y_valid stays 0.
REQ-043 Input gaps: i_len=4, i_x_valid toggling 1,0,1,0,... Required: exactly 4 fires; o_step sequence 0->1->2->3->4; o_cell_sel=0 only on the first fire.
REQ-044 Mid-sequence reset: rst asserted after 2 of 5 steps, then a new start with i_len=1. Required: no o_done for the aborted run; the new run fires with o_cell_sel=0.
REQ-045 Start while busy: i_start pulsed during RUN with a different i_len. Required: no effect; the original step count completes.
